// File: rtl/axi4_lite_handshake_scheduler_if.sv
// AXI4-Lite valid/ready handshake bundle (AW, W, B, AR, R) with no payload.
// The slave modport is the scheduler side. The master modport is the VIP/driver side.
interface axi4_lite_handshake_scheduler_if;
  logic awvalid;
  logic awready;
  logic wvalid;
  logic wready;
  logic bvalid;
  logic bready;
  logic arvalid;
  logic arready;
  logic rvalid;
  logic rready;

  modport slave (
    input  awvalid, wvalid, bready, arvalid, rready,
    output awready, wready, bvalid, arready, rvalid
  );

  modport master (
    output awvalid, wvalid, bready, arvalid, rready,
    input  awready, wready, bvalid, arready, rvalid
  );
endinterface

// File: rtl/axi4_lite_handshake_scheduler.sv
// Slave-side AXI4-Lite handshake scheduler. It captures AW/W/AR handshakes and grants one
// shared backend slot round-robin between reads and writes. It answers on B or R after cfgWait cycles.
module axi4_lite_handshake_scheduler #(
  parameter int WAIT_WIDTH = 4
) (
  input  logic                           aclk,
  input  logic                           areset,
  axi4_lite_handshake_scheduler_if.slave bus,
  input  logic [WAIT_WIDTH-1:0]          cfgWait,
  output logic                           busy,
  output logic                           lastGrant
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP_W,
    RESP_R
  } state_t;

  state_t                state, state_n;
  logic [WAIT_WIDTH-1:0] cnt, cnt_n;
  logic                  last_grant_n;
  logic                  aw_held, w_held, ar_held;
  logic                  aw_held_n, w_held_n, ar_held_n;
  logic                  awready_q, wready_q, arready_q;
  logic                  wr_pend, rd_pend, grant_rd;

  // Only captured requests are arbitrated. A handshake in this cycle waits for the next IDLE cycle.
  assign wr_pend = aw_held && w_held;
  assign rd_pend = ar_held;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    last_grant_n = lastGrant;
    aw_held_n    = aw_held;
    w_held_n     = w_held;
    ar_held_n    = ar_held;
    grant_rd     = 1'b0;

    if (bus.awvalid && awready_q) aw_held_n = 1'b1;
    if (bus.wvalid  && wready_q)  w_held_n  = 1'b1;
    if (bus.arvalid && arready_q) ar_held_n = 1'b1;

    case (state)
      IDLE: begin
        if (wr_pend || rd_pend) begin
          grant_rd     = rd_pend && (!wr_pend || !lastGrant);
          last_grant_n = grant_rd;
          // The grant cycle counts as the first wait cycle. This puts the response at grant+1+cfgWait.
          if (cfgWait == '0) begin
            state_n = grant_rd ? RESP_R : RESP_W;
          end else begin
            cnt_n   = cfgWait - WAIT_WIDTH'(1);
            state_n = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt == '0) state_n = lastGrant ? RESP_R : RESP_W;
        else           cnt_n   = cnt - WAIT_WIDTH'(1);
      end
      RESP_W: begin
        if (bus.bready) begin
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          state_n   = IDLE;
        end
      end
      RESP_R: begin
        if (bus.rready) begin
          ar_held_n = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments, so every register samples the pre-edge values together.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      cnt       <= '0;
      lastGrant <= 1'b1;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      ar_held   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      lastGrant <= last_grant_n;
      aw_held   <= aw_held_n;
      w_held    <= w_held_n;
      ar_held   <= ar_held_n;
      // Readies are registered from the next held flags. They stay low through reset and carry no path from valid.
      awready_q <= !aw_held_n;
      wready_q  <= !w_held_n;
      arready_q <= !ar_held_n;
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.arready = arready_q;
  assign bus.bvalid  = (state == RESP_W);
  assign bus.rvalid  = (state == RESP_R);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_axi4_lite_handshake_scheduler.sv
// Scenario bench for axi4_lite_handshake_scheduler. Expected responses (direction and first-valid
// cycle) are queued when stimulus is driven, then popped when bvalid/rvalid rises.
module tb_axi4_lite_handshake_scheduler;
  localparam int WW = 4;

  logic          aclk = 1'b0;
  logic          areset;
  logic [WW-1:0] cfgWait;
  logic          busy;
  logic          lastGrant;

  axi4_lite_handshake_scheduler_if bus ();

  axi4_lite_handshake_scheduler #(.WAIT_WIDTH(WW)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .bus       (bus),
    .cfgWait   (cfgWait),
    .busy      (busy),
    .lastGrant (lastGrant)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    bit is_read;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  bit   bv_prev = 1'b0;
  bit   rv_prev = 1'b0;

  // Response monitor: each rising bvalid/rvalid must match the oldest expected response.
  always @(negedge aclk) begin
    if ((bus.bvalid && !bv_prev) || (bus.rvalid && !rv_prev)) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: got %s at cycle %0d, required none", bus.rvalid ? "R" : "B", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (bus.rvalid !== mon_e.is_read || cyc !== mon_e.due) begin
          fails++;
          $display("FAIL resp_order_timing: got %s at cycle %0d, required %s at cycle %0d",
                   bus.rvalid ? "R" : "B", cyc, mon_e.is_read ? "R" : "B", mon_e.due);
        end
      end
    end
    bv_prev = bus.bvalid;
    rv_prev = bus.rvalid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while (!(!busy && bus.awready && bus.wready && bus.arready) && n < 64) begin
      tick();
      n++;
    end
    tests++;
    if ({busy, bus.awready, bus.wready, bus.arready} !== 4'b0111) begin
      fails++;
      $display("FAIL %s_quiet: busy/aw/w/ar ready = %b, required 0111", name,
               {busy, bus.awready, bus.wready, bus.arready});
    end
  endtask

  task automatic clear_valids();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.arvalid = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    clear_valids();
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    cfgWait    = '0;
    tick();
    tick();
    tests++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, busy, lastGrant} !== 7'b0000001) begin
      fails++;
      $display("FAIL reset_outputs: aw/w/ar/b/r/busy/lastGrant = %b, required 0000001",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, busy, lastGrant});
    end
    areset = 1'b0;
    tick();
    tests++;
    if ({bus.awready, bus.wready, bus.arready, busy} !== 4'b1110) begin
      fails++;
      $display("FAIL reset_release: aw/w/ar ready/busy = %b, required 1110",
               {bus.awready, bus.wready, bus.arready, busy});
    end
  endtask

  task automatic test_basic_write();
    int c;
    cfgWait    = 4'd3;
    bus.bready = 1'b1;
    c = cyc;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    sb.push_back('{is_read: 1'b0, due: c + 5});
    tick();
    tests++;
    if ({bus.awready, bus.wready, busy} !== 3'b000) begin
      fails++;
      $display("FAIL basic_capture: aw/w ready/busy = %b, required 000", {bus.awready, bus.wready, busy});
    end
    clear_valids();
    tick();
    tests++;
    if ({busy, lastGrant} !== 2'b10) begin
      fails++;
      $display("FAIL basic_grant: busy/lastGrant = %b, required 10", {busy, lastGrant});
    end
    tick_to(c + 6);
    tests++;
    if ({bus.bvalid, bus.awready, bus.wready, busy} !== 4'b0110) begin
      fails++;
      $display("FAIL basic_after_b: bvalid/aw/w ready/busy = %b, required 0110",
               {bus.bvalid, bus.awready, bus.wready, busy});
    end
  endtask

  task automatic test_w_before_aw();
    int c;
    cfgWait    = 4'd0;
    bus.bready = 1'b0;
    c = cyc;
    bus.wvalid = 1'b1;
    tick();
    tests++;
    if ({bus.wready, bus.awready} !== 2'b01) begin
      fails++;
      $display("FAIL wfirst_capture: w/aw ready = %b, required 01", {bus.wready, bus.awready});
    end
    bus.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({busy, bus.bvalid} !== 2'b00) begin
        fails++;
        $display("FAIL wfirst_no_grant: busy/bvalid = %b at cycle %0d, required 00", {busy, bus.bvalid}, cyc);
      end
    end
    bus.awvalid = 1'b1;
    sb.push_back('{is_read: 1'b0, due: c + 6});
    tick();
    tests++;
    if ({bus.awready, busy} !== 2'b00) begin
      fails++;
      $display("FAIL wfirst_aw_capture: awready/busy = %b, required 00", {bus.awready, busy});
    end
    bus.awvalid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({bus.bvalid, busy} !== 2'b11) begin
        fails++;
        $display("FAIL wfirst_b_hold: bvalid/busy = %b at cycle %0d, required 11", {bus.bvalid, busy}, cyc);
      end
      if (i < 4) tick();
    end
    bus.bready = 1'b1;
    tick();
    tests++;
    if ({bus.bvalid, busy} !== 2'b00) begin
      fails++;
      $display("FAIL wfirst_b_done: bvalid/busy = %b, required 00", {bus.bvalid, busy});
    end
  endtask

  task automatic test_tie();
    int c;
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    tick();
    cfgWait    = 4'd1;
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    // First tie after reset: write wins, then read.
    c = cyc;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.arvalid = 1'b1;
    sb.push_back('{is_read: 1'b0, due: c + 3});
    sb.push_back('{is_read: 1'b1, due: c + 6});
    tick();
    clear_valids();
    tick();
    tests++;
    if (lastGrant !== 1'b0) begin
      fails++;
      $display("FAIL tie1_first: lastGrant = %b, required 0", lastGrant);
    end
    tick_to(c + 5);
    tests++;
    if (lastGrant !== 1'b1) begin
      fails++;
      $display("FAIL tie1_second: lastGrant = %b, required 1", lastGrant);
    end
    wait_quiet("tie1");
    // A lone write leaves lastGrant = 0, so the next tie goes to the read.
    c = cyc;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    sb.push_back('{is_read: 1'b0, due: c + 3});
    tick();
    clear_valids();
    wait_quiet("lone_write");
    c = cyc;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.arvalid = 1'b1;
    sb.push_back('{is_read: 1'b1, due: c + 3});
    sb.push_back('{is_read: 1'b0, due: c + 6});
    tick();
    clear_valids();
    tick();
    tests++;
    if (lastGrant !== 1'b1) begin
      fails++;
      $display("FAIL tie2_first: lastGrant = %b, required 1", lastGrant);
    end
    tick_to(c + 5);
    tests++;
    if (lastGrant !== 1'b0) begin
      fails++;
      $display("FAIL tie2_second: lastGrant = %b, required 0", lastGrant);
    end
    wait_quiet("tie2");
  endtask

  task automatic test_read_during_write();
    int c;
    cfgWait    = 4'd5;
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    c = cyc;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    sb.push_back('{is_read: 1'b0, due: c + 7});
    tick();
    clear_valids();
    tick_to(c + 3);
    bus.arvalid = 1'b1;
    sb.push_back('{is_read: 1'b1, due: c + 14});
    tick();
    tests++;
    if ({bus.arready, busy} !== 2'b01) begin
      fails++;
      $display("FAIL rdw_ar_capture: arready/busy = %b, required 01", {bus.arready, busy});
    end
    bus.arvalid = 1'b0;
    tick_to(c + 7);
    // A new AW during the B handshake cycle must wait one cycle.
    bus.awvalid = 1'b1;
    tests++;
    if ({bus.bvalid, bus.awready} !== 2'b10) begin
      fails++;
      $display("FAIL rdw_b_cycle: bvalid/awready = %b, required 10", {bus.bvalid, bus.awready});
    end
    tick();
    tests++;
    if ({bus.awready, bus.rvalid} !== 2'b10) begin
      fails++;
      $display("FAIL rdw_aw_reopen: awready/rvalid = %b, required 10", {bus.awready, bus.rvalid});
    end
    tick();
    tests++;
    if (bus.awready !== 1'b0) begin
      fails++;
      $display("FAIL rdw_aw_recapture: awready = %b, required 0", bus.awready);
    end
    bus.awvalid = 1'b0;
    tick_to(c + 15);
    bus.wvalid = 1'b1;
    sb.push_back('{is_read: 1'b0, due: c + 22});
    tick();
    bus.wvalid = 1'b0;
    wait_quiet("rdw");
  endtask

  task automatic test_cfg_change();
    int c;
    cfgWait = 4'd2;
    c = cyc;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    sb.push_back('{is_read: 1'b0, due: c + 4});
    tick();
    clear_valids();
    tick();
    cfgWait = 4'd7;
    wait_quiet("cfg_change");
  endtask

  task automatic test_reset_during_resp();
    int c;
    cfgWait    = 4'd0;
    bus.rready = 1'b0;
    c = cyc;
    bus.arvalid = 1'b1;
    sb.push_back('{is_read: 1'b1, due: c + 2});
    tick();
    bus.arvalid = 1'b0;
    tick_to(c + 3);
    tests++;
    if ({bus.rvalid, busy} !== 2'b11) begin
      fails++;
      $display("FAIL rst_resp_hold: rvalid/busy = %b, required 11", {bus.rvalid, busy});
    end
    areset = 1'b1;
    tick();
    tests++;
    if ({bus.rvalid, busy, lastGrant, bus.awready, bus.wready, bus.arready} !== 6'b001000) begin
      fails++;
      $display("FAIL rst_resp_drop: rvalid/busy/lastGrant/aw/w/ar = %b, required 001000",
               {bus.rvalid, busy, lastGrant, bus.awready, bus.wready, bus.arready});
    end
    areset = 1'b0;
    tick();
    tests++;
    if ({bus.awready, bus.wready, bus.arready, bus.rvalid, busy} !== 5'b11100) begin
      fails++;
      $display("FAIL rst_resp_release: aw/w/ar ready/rvalid/busy = %b, required 11100",
               {bus.awready, bus.wready, bus.arready, bus.rvalid, busy});
    end
    tick();
    tests++;
    if ({bus.rvalid, busy} !== 2'b00) begin
      fails++;
      $display("FAIL rst_resp_no_revive: rvalid/busy = %b, required 00", {bus.rvalid, busy});
    end
  endtask

  initial begin
    areset      = 1'b1;
    cfgWait     = '0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.arvalid = 1'b0;
    bus.bready  = 1'b0;
    bus.rready  = 1'b0;

    test_reset();
    test_basic_write();
    test_w_before_aw();
    test_tie();
    test_read_during_write();
    test_cfg_change();
    test_reset_during_resp();

    tick();
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
